// File: rtl/control_pipe_unit.sv
// control_pipe_unit
//   Registered RV32I control decoder. It decodes the ID-stage opcode into a
//   5-bit control bundle, then carries bundle, rd and valid through DEPTH
//   control stages (stage 0 = EX). It also detects load-use hazards against
//   the EX instruction and inserts one bubble for each. A global stall
//   freezes every stage, and a branch/jump flush kills the ID instruction.
//
//   Bundle bits: [0] mem_read [1] mem_write [2] reg_write [3] jump [4] branch
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   id_valid      ID holds a real instruction
//   op, rd, rs1, rs2  ID instruction fields
//   stall_in      freeze all stages (flush and hazard are ignored)
//   flush         replace the ID instruction with a bubble
//   hazard_stall  combinational load-use hazard; upstream must hold PC and ID
//   st_valid      per-stage valid, bit k = stage k
//   st_ctrl       per-stage bundle, slice [5k+4:5k] = stage k
//   st_rd         per-stage destination register, slice [RW*k +: RW]
//   st_illegal    stage-0 instruction had an undecodable opcode
//   hazard_cnt, flush_cnt  saturating perf counters (CTRL_PERF_CNT_EN only)
//
// Optional feature macro: CTRL_PERF_CNT_EN enables the perf counters and
// their ports. With the macro undefined, the pipeline behaves identically.
module control_pipe_unit #(
  parameter int DEPTH = 3,
  parameter int RW    = 5,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [6:0]         op,
  input  logic [RW-1:0]      rd,
  input  logic [RW-1:0]      rs1,
  input  logic [RW-1:0]      rs2,
  input  logic               stall_in,
  input  logic               flush,
  output logic               hazard_stall,
  output logic [DEPTH-1:0]   st_valid,
  output logic [5*DEPTH-1:0] st_ctrl,
  output logic [RW*DEPTH-1:0] st_rd,
`ifdef CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0]   hazard_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
`endif
  output logic               st_illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic [DEPTH-1:0]    valid_q,   valid_d;
  logic [5*DEPTH-1:0]  ctrl_q,    ctrl_d;
  logic [RW*DEPTH-1:0] rd_q,      rd_d;
  logic                illegal_q, illegal_d;

  logic [4:0]    dec_ctrl;
  logic          dec_illegal;
  logic [RW-1:0] ex_rd;

  // Decode of the ID instruction. Invalid slots decode to an all-zero bundle.
  always_comb begin
    dec_ctrl    = 5'b00000;
    dec_illegal = 1'b0;
    unique case (op)
      OP_R, OP_I_IMM, OP_LUI, OP_AUIPC: dec_ctrl = 5'b00100;
      OP_LOAD:                          dec_ctrl = 5'b00101;
      OP_S:                             dec_ctrl = 5'b00010;
      OP_B:                             dec_ctrl = 5'b10000;
      OP_JAL, OP_JALR:                  dec_ctrl = 5'b01100;
      default:                          dec_illegal = 1'b1;
    endcase
    // x0 is never written, so reg_write is suppressed for rd == 0.
    if (rd == '0) dec_ctrl[2] = 1'b0;
    if (!id_valid) begin
      dec_ctrl    = 5'b00000;
      dec_illegal = 1'b0;
    end
  end

  // Load-use hazard against EX. The check is conservative: rs2 is compared
  // even for formats that do not read it.
  assign ex_rd = rd_q[RW-1:0];
  assign hazard_stall = id_valid & valid_q[0] & ctrl_q[0] & (ex_rd != '0) &
                        ((ex_rd == rs1) | (ex_rd == rs2));

  // Next-state logic for the stages. Flush and hazard both insert a bubble
  // into stage 0 while the older stages keep shifting.
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    if (!stall_in) begin
      valid_d   = {valid_q[DEPTH-2:0], 1'b0};
      ctrl_d    = {ctrl_q[5*(DEPTH-1)-1:0], 5'b00000};
      rd_d      = {rd_q[RW*(DEPTH-1)-1:0], {RW{1'b0}}};
      illegal_d = 1'b0;
      if (!flush && !hazard_stall) begin
        valid_d[0]     = id_valid;
        ctrl_d[4:0]    = dec_ctrl;
        rd_d[RW-1:0]   = id_valid ? rd : '0;
        illegal_d      = dec_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      ctrl_q    <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  assign st_valid   = valid_q;
  assign st_ctrl    = ctrl_q;
  assign st_rd      = rd_q;
  assign st_illegal = illegal_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

  // Counters saturate at all-ones instead of wrapping.
  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (hazard_stall && !stall_in && !flush && (hazard_cnt_q != '1))
      hazard_cnt_d = hazard_cnt_q + 1'b1;
    if (flush && !stall_in && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      hazard_cnt_q <= hazard_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign hazard_cnt = hazard_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  logic [31:0] cnt_w_unused;
  assign cnt_w_unused = CNT_W;
`endif

endmodule
